router_flit_monitor: RTL and testbench

Parametrised per-port flit activity monitor for the mesh router; successor to the router's fixed 5-port, 1024-cycle, 20-bit activity counter.
- Counts FIFO write strobes per input port and in total over a programmable sampling window.
- Publishes snapshots with a valid pulse, tracks peak total load and flags saturation.
- Sits beside the router input FIFOs in the local clock domain; taps each FIFO's write signal.

---
 rtl/router_flit_monitor_pkg.sv | 35 +++
 rtl/router_flit_monitor_sat_counter.sv | 33 +++
 rtl/router_flit_monitor.sv | 128 ++++++++++++
 tb/tb_router_flit_monitor.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/router_flit_monitor_pkg.sv
// Shared constants and arithmetic helpers for the router flit activity monitor.
// Counters are limited to 32 bits by the helper functions below.
package router_flit_monitor_pkg;

    localparam int NORTH      = 0;
    localparam int EAST       = 1;
    localparam int SOUTH      = 2;
    localparam int WEST       = 3;
    localparam int LOCAL      = 4;
    localparam int DIRECTIONS = 5;

    // Bits needed to hold the number of set strobes across n ports.
    function automatic int popcount_width(input int n);
        return $clog2(n + 1);
    endfunction

    // a + b clamped to the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

    // True when a + b would exceed the range of a w-bit counter.
    function automatic logic sat_clamps(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return sum > lim;
    endfunction

endpackage

// File: rtl/router_flit_monitor_sat_counter.sv
// Saturating accumulator: adds inc each enabled cycle, or restarts from zero when clear is set.
// sum/clamp expose this cycle's saturated result so the owner can snapshot it before the clear.
module router_flit_monitor_sat_counter
    import router_flit_monitor_pkg::*;
#(
    parameter int CNT_W = 20,
    parameter int INC_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] sum,
    output logic             clamp
);

    logic [CNT_W-1:0] count_reg;

    always_comb begin
        sum   = CNT_W'(sat_add(32'(count_reg), 32'(inc), CNT_W));
        clamp = sat_clamps(32'(count_reg), 32'(inc), CNT_W);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= clear ? '0 : sum;
        end
    end

endmodule

// File: rtl/router_flit_monitor.sv
// Per-port and total flit counter over a 2^WIN_LOG2-cycle window, with snapshot publication,
// peak-total tracking and saturation flags.
module router_flit_monitor
    import router_flit_monitor_pkg::*;
#(
    parameter int NUM_PORTS = DIRECTIONS,
    parameter int CNT_W     = 20,
    parameter int WIN_LOG2  = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [NUM_PORTS-1:0]       write,
    input  logic                       clear_peak,
    output logic [NUM_PORTS*CNT_W-1:0] port_count,
    output logic [CNT_W-1:0]           total_count,
    output logic                       snap_valid,
    output logic                       sat,
    output logic [CNT_W-1:0]           peak_total,
    output logic                       sat_sticky
);

    localparam int PC_W    = popcount_width(NUM_PORTS);
    localparam int NUM_CNT = NUM_PORTS + 1;

    logic [WIN_LOG2-1:0]        win_reg;
    logic                       last_cycle;
    logic                       fire;
    logic [PC_W-1:0]            write_pop;
    logic [CNT_W-1:0]           sum_vec [NUM_CNT];
    logic [NUM_CNT-1:0]         clamp_vec;
    logic                       new_sat;
    logic                       win_sat_reg;
    logic [NUM_PORTS*CNT_W-1:0] port_count_reg;
    logic [CNT_W-1:0]           total_reg;
    logic                       snap_reg;
    logic                       sat_reg;
    logic [CNT_W-1:0]           peak_reg;
    logic                       sticky_reg;

    assign last_cycle = &win_reg;
    assign fire       = enable && last_cycle;
    // Clamp bits are only meaningful on enabled cycles; callers gate with enable.
    assign new_sat    = win_sat_reg | (|clamp_vec);

    always_comb begin
        write_pop = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            write_pop = write_pop + PC_W'(write[i]);
        end
    end

    // Counters 0..NUM_PORTS-1 track single ports; the last one tracks the total.
    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            if (gi < NUM_PORTS) begin : g_port
                router_flit_monitor_sat_counter #(
                    .CNT_W (CNT_W),
                    .INC_W (1)
                ) u_cnt (
                    .clk    (clk),
                    .reset  (reset),
                    .enable (enable),
                    .clear  (last_cycle),
                    .inc    (write[gi]),
                    .sum    (sum_vec[gi]),
                    .clamp  (clamp_vec[gi])
                );
            end else begin : g_total
                router_flit_monitor_sat_counter #(
                    .CNT_W (CNT_W),
                    .INC_W (PC_W)
                ) u_cnt (
                    .clk    (clk),
                    .reset  (reset),
                    .enable (enable),
                    .clear  (last_cycle),
                    .inc    (write_pop),
                    .sum    (sum_vec[gi]),
                    .clamp  (clamp_vec[gi])
                );
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            win_reg        <= '0;
            win_sat_reg    <= 1'b0;
            port_count_reg <= '0;
            total_reg      <= '0;
            snap_reg       <= 1'b0;
            sat_reg        <= 1'b0;
            peak_reg       <= '0;
            sticky_reg     <= 1'b0;
        end else begin
            snap_reg <= 1'b0;
            if (enable) begin
                win_reg     <= win_reg + 1'b1;
                win_sat_reg <= last_cycle ? 1'b0 : new_sat;
            end
            if (fire) begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    port_count_reg[p*CNT_W +: CNT_W] <= sum_vec[p];
                end
                total_reg <= sum_vec[NUM_PORTS];
                snap_reg  <= 1'b1;
                sat_reg   <= new_sat;
                // A simultaneous clear_peak wipes history before the new total is considered.
                if (clear_peak || (sum_vec[NUM_PORTS] > peak_reg)) begin
                    peak_reg <= sum_vec[NUM_PORTS];
                end
                sticky_reg <= (sticky_reg & ~clear_peak) | new_sat;
            end else if (clear_peak) begin
                peak_reg   <= '0;
                sticky_reg <= 1'b0;
            end
        end
    end

    assign port_count  = port_count_reg;
    assign total_count = total_reg;
    assign snap_valid  = snap_reg;
    assign sat         = sat_reg;
    assign peak_total  = peak_reg;
    assign sat_sticky  = sticky_reg;

endmodule

// File: tb/tb_router_flit_monitor.sv
// Bench for router_flit_monitor: two instances (8-bit and 6-bit counters, 16-cycle window)
// share directed and random stimulus and are compared every cycle against a window-level model.
module tb_router_flit_monitor;

    localparam int NP   = 5;
    localparam int WL2  = 4;
    localparam int WIN  = 1 << WL2;
    localparam int W_A  = 8;
    localparam int W_B  = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic [NP-1:0] write = '0;
    logic clear_peak = 1'b0;

    logic [NP*W_A-1:0] port_count_a;
    logic [W_A-1:0]    total_a, peak_a;
    logic              snap_a, sat_a, sticky_a;
    logic [NP*W_B-1:0] port_count_b;
    logic [W_B-1:0]    total_b, peak_b;
    logic              snap_b, sat_b, sticky_b;

    int checks = 0;
    int failures = 0;

    // Model state: true (unclamped) counts of the current window and expected published outputs.
    int acc_port [NP];
    int acc_tot;
    int pos;
    int e_port [2][NP];
    int e_tot [2];
    int e_peak [2];
    bit e_sat [2];
    bit e_sticky [2];
    bit e_snap;

    always #5 clk = ~clk;

    router_flit_monitor #(.NUM_PORTS(NP), .CNT_W(W_A), .WIN_LOG2(WL2)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .write(write), .clear_peak(clear_peak),
        .port_count(port_count_a), .total_count(total_a), .snap_valid(snap_a),
        .sat(sat_a), .peak_total(peak_a), .sat_sticky(sticky_a)
    );

    router_flit_monitor #(.NUM_PORTS(NP), .CNT_W(W_B), .WIN_LOG2(WL2)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .write(write), .clear_peak(clear_peak),
        .port_count(port_count_b), .total_count(total_b), .snap_valid(snap_b),
        .sat(sat_b), .peak_total(peak_b), .sat_sticky(sticky_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit en, input logic [NP-1:0] wr, input bit clr);
        int mx;
        e_snap = 1'b0;
        if (rst) begin
            pos = 0;
            acc_tot = 0;
            for (int p = 0; p < NP; p++) acc_port[p] = 0;
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < NP; p++) e_port[k][p] = 0;
                e_tot[k] = 0; e_peak[k] = 0; e_sat[k] = 1'b0; e_sticky[k] = 1'b0;
            end
            return;
        end
        if (clr) begin
            for (int k = 0; k < 2; k++) begin
                e_peak[k] = 0; e_sticky[k] = 1'b0;
            end
        end
        if (en) begin
            for (int p = 0; p < NP; p++) acc_port[p] += int'(wr[p]);
            acc_tot += $countones(wr);
            pos++;
            if (pos == WIN) begin
                for (int k = 0; k < 2; k++) begin
                    mx = (1 << ((k == 0) ? W_A : W_B)) - 1;
                    for (int p = 0; p < NP; p++) e_port[k][p] = (acc_port[p] > mx) ? mx : acc_port[p];
                    e_tot[k] = (acc_tot > mx) ? mx : acc_tot;
                    // The total is never below any port count, so it alone decides saturation.
                    e_sat[k] = (acc_tot > mx);
                    if (e_tot[k] > e_peak[k]) e_peak[k] = e_tot[k];
                    e_sticky[k] = e_sticky[k] | e_sat[k];
                end
                e_snap = 1'b1;
                acc_tot = 0;
                for (int p = 0; p < NP; p++) acc_port[p] = 0;
                pos = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic [NP*W_A-1:0] ep_a;
        logic [NP*W_B-1:0] ep_b;
        for (int p = 0; p < NP; p++) begin
            ep_a[p*W_A +: W_A] = W_A'(e_port[0][p]);
            ep_b[p*W_B +: W_B] = W_B'(e_port[1][p]);
        end
        check("a.port_count", 64'(port_count_a), 64'(ep_a));
        check("a.total_count", 64'(total_a), 64'(e_tot[0]));
        check("a.snap_valid", 64'(snap_a), 64'(e_snap));
        check("a.sat", 64'(sat_a), 64'(e_sat[0]));
        check("a.peak_total", 64'(peak_a), 64'(e_peak[0]));
        check("a.sat_sticky", 64'(sticky_a), 64'(e_sticky[0]));
        check("b.port_count", 64'(port_count_b), 64'(ep_b));
        check("b.total_count", 64'(total_b), 64'(e_tot[1]));
        check("b.snap_valid", 64'(snap_b), 64'(e_snap));
        check("b.sat", 64'(sat_b), 64'(e_sat[1]));
        check("b.peak_total", 64'(peak_b), 64'(e_peak[1]));
        check("b.sat_sticky", 64'(sticky_b), 64'(e_sticky[1]));
    endtask

    task automatic drive_cycle(input bit rst, input bit en, input logic [NP-1:0] wr, input bit clr);
        reset = rst;
        enable = en;
        write = wr;
        clear_peak = clr;
        @(posedge clk);
        #1;
        model_step(rst, en, wr, clr);
        compare_all();
    endtask

    initial begin
        // Reset, then a single busy port for one window.
        drive_cycle(1'b1, 1'b0, 5'b00000, 1'b0);
        drive_cycle(1'b1, 1'b1, 5'b11111, 1'b0);
        for (int i = 0; i < WIN; i++) drive_cycle(1'b0, 1'b1, 5'b00001, 1'b0);
        check("plan1.snap", 64'(snap_a), 64'd1);
        check("plan1.port0", 64'(port_count_a[W_A-1:0]), 64'd16);
        check("plan1.total", 64'(total_a), 64'd16);
        drive_cycle(1'b0, 1'b0, 5'b00000, 1'b0);

        // All ports busy (saturates the 6-bit instance), then an idle window.
        for (int i = 0; i < WIN; i++) drive_cycle(1'b0, 1'b1, 5'b11111, 1'b0);
        check("plan2.total_a", 64'(total_a), 64'd80);
        check("plan2.total_b", 64'(total_b), 64'd63);
        check("plan2.sat_b", 64'(sat_b), 64'd1);
        check("plan2.port4_b", 64'(port_count_b[4*W_B +: W_B]), 64'd16);
        for (int i = 0; i < WIN; i++) drive_cycle(1'b0, 1'b1, 5'b00000, 1'b0);
        check("plan2.peak_a", 64'(peak_a), 64'd80);

        // Strobes only on the last window cycle must be counted.
        for (int i = 0; i < WIN - 1; i++) drive_cycle(1'b0, 1'b1, 5'b00000, 1'b0);
        drive_cycle(1'b0, 1'b1, 5'b10100, 1'b0);
        check("plan3.total", 64'(total_a), 64'd2);

        // clear_peak while idle.
        drive_cycle(1'b0, 1'b0, 5'b00000, 1'b1);
        check("plan4.peak_b", 64'(peak_b), 64'd0);

        // Disabled cycles in mid-window are ignored and delay the snapshot.
        for (int i = 0; i < 8; i++) drive_cycle(1'b0, 1'b1, 5'b11111, 1'b0);
        for (int i = 0; i < 7; i++) drive_cycle(1'b0, 1'b0, 5'b11111, 1'b0);
        for (int i = 0; i < 8; i++) drive_cycle(1'b0, 1'b1, 5'b11111, 1'b0);

        // Clear coinciding with a snapshot.
        for (int i = 0; i < WIN - 1; i++) drive_cycle(1'b0, 1'b1, 5'b00011, 1'b0);
        drive_cycle(1'b0, 1'b1, 5'b00011, 1'b1);

        // Reset in the middle of a busy window discards the partial counts.
        for (int i = 0; i < 8; i++) drive_cycle(1'b0, 1'b1, 5'b11111, 1'b0);
        drive_cycle(1'b1, 1'b1, 5'b11111, 1'b0);
        for (int i = 0; i < WIN; i++) drive_cycle(1'b0, 1'b1, 5'b00010, 1'b0);
        check("plan6.total", 64'(total_a), 64'd16);

        // Random traffic with occasional stalls, clears and resets.
        for (int i = 0; i < 400; i++) begin
            logic [NP-1:0] wr;
            wr = ($urandom_range(0, 1) == 0) ? 5'b11111 : NP'($urandom);
            drive_cycle($urandom_range(0, 149) == 0, $urandom_range(0, 9) != 0, wr,
                        $urandom_range(0, 24) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
